// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
//
// Cleans up raw switch/button pins before the game state machine sees them.
// Every channel passes through three stages:
//   1. a SYNC_STAGES-deep metastability synchroniser, clocked every cycle;
//   2. a debounce counter that advances only on sample ticks. It accepts a
//      new level after DEB_COUNT consecutive ticks that disagree with the
//      current level;
//   3. registered one-cycle rise/fall pulses that line up with the level change.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset (clears every flop)
//   tick_in    in   sample strobe, one clk wide (may be held high)
//   raw_in     in   [N_CH] asynchronous raw pin levels
//   level_out  out  [N_CH] debounced level per channel
//   rise_out   out  [N_CH] one-cycle pulse on each 0->1 of level_out
//   fall_out   out  [N_CH] one-cycle pulse on each 1->0 of level_out
//   stable_out out  high when no channel has a pending change
// -----------------------------------------------------------------------------
module input_conditioner #(
  parameter int N_CH        = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_COUNT   = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tick_in,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] level_out,
  output logic [N_CH-1:0] rise_out,
  output logic [N_CH-1:0] fall_out,
  output logic            stable_out
);

  // The counter only ever holds 0..DEB_COUNT-1. Reaching the last value on a
  // disagreeing tick commits the toggle, so the counter can never wrap.
  localparam int            CW       = $clog2(DEB_COUNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_COUNT - 1);

  // Synchroniser chain: r_sync[0] samples the pin, r_sync[SYNC_STAGES-1] is
  // the clean version that the debouncer uses.
  logic [N_CH-1:0] r_sync [SYNC_STAGES];
  logic [N_CH-1:0] w_sync;
  logic [N_CH-1:0] w_ch_idle;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_sync[s] <= '0;
      end
    end else begin
      r_sync[0] <= raw_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [CW-1:0] r_cnt;
      logic          r_level;
      logic          r_rise;
      logic          r_fall;
      logic          w_differ;

      assign w_differ = w_sync[gi] ^ r_level;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_cnt   <= '0;
          r_level <= 1'b0;
          r_rise  <= 1'b0;
          r_fall  <= 1'b0;
        end else begin
          // Pulses last one cycle unless a toggle re-arms them below.
          r_rise <= 1'b0;
          r_fall <= 1'b0;
          if (tick_in) begin
            if (!w_differ) begin
              // Any agreeing tick throws away partial progress.
              r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
              r_cnt   <= '0;
              r_level <= ~r_level;
              // The pulse is registered with the new level, so it is high
              // during the first cycle that level_out shows the new value.
              r_rise  <= ~r_level;
              r_fall  <= r_level;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
      end

      assign level_out[gi] = r_level;
      assign rise_out[gi]  = r_rise;
      assign fall_out[gi]  = r_fall;
      assign w_ch_idle[gi] = (r_cnt == '0) && !w_differ;
    end
  endgenerate

  // Driven only by flops, so there is no combinational path from raw_in.
  assign stable_out = &w_ch_idle;

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Conditions the raw Tiny Tapeout switch and button pins before they reach the game state machine.
- Each channel is synchronised, debounced against a slow sample strobe, and produces a clean level plus one-cycle rise/fall pulses.
- Sits between ui_in and the game logic, which consumes level_out (switch state) and rise_out (button presses).
- The sample strobe comes from an existing clock-divider pulse output.

Parameters:
- N_CH, 8, number of input channels (ui_in[7:0]: [7:4] buttons, [3:0] switches).
- SYNC_STAGES, 2, flops in each metastability synchroniser chain; legal values are 2 or more.
- DEB_COUNT, 4, consecutive differing sampled ticks needed to accept a new level; legal values are 1 or more.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- tick_in  input  1  sample strobe, one clk wide; may be held high to sample every cycle.
- raw_in  input  N_CH  asynchronous raw pin levels.
- level_out  output  N_CH  debounced level per channel.
- rise_out  output  N_CH  one-cycle pulse on each 0->1 transition of level_out.
- fall_out  output  N_CH  one-cycle pulse on each 1->0 transition of level_out.
- stable_out  output  1  high when no channel has a pending change.

Behaviour:
- Interface: reset is asynchronous, active-high; clock is clk. All flops clear immediately on reset assertion.
- Reset values:
  - Synchroniser flops, counters, level_out, rise_out and fall_out are all 0.
  - stable_out is therefore 1.
- Synchroniser:
  - Per channel, raw_in feeds a SYNC_STAGES-deep chain of flops clocked on every clk, independent of tick_in.
  - sync[i] is the last stage of the chain.
- Debounce counter: per channel, width clog2(DEB_COUNT+1). Updated only on clk edges where tick_in=1.
  - If sync[i]==level_out[i]: counter clears to 0.
  - If sync[i]!=level_out[i] and counter+1 < DEB_COUNT: counter increments.
  - If sync[i]!=level_out[i] and counter+1 == DEB_COUNT: level_out[i] toggles and counter clears to 0.
  - When tick_in=0, counter and level_out hold.
- Edge pulses:
  - rise_out[i] is registered and asserted for exactly the first cycle level_out[i] reads 1 after a toggle. fall_out[i] behaves the same for the first cycle reading 0.
  - rise_out[i] and fall_out[i] are never high together; both are low in every other cycle.
- stable_out: combinational AND over all channels of (counter==0 and sync==level_out).
- Latency, with tick_in held 1:
  - A clean step on raw_in first captured at edge k appears on level_out, rise_out and fall_out after edge k+SYNC_STAGES+DEB_COUNT-1.
  - With sparse ticks, the change needs DEB_COUNT qualifying ticks after sync changes.
- Glitch rejection:
  - Any return of sync to level_out on a tick before the count completes discards all progress.
  - Non-consecutive disagreeing ticks never accumulate.
- Channels are fully independent. Any number of channels may toggle on the same edge, each with its own pulse.
- Counter wrap: impossible by construction; the counter never exceeds DEB_COUNT-1.
- Reset mid-count: counters clear, level_out returns to 0, and no fall pulse is generated for channels that were 1.
- After reset releases, a channel whose pin is held high gets a normal rise after the full latency.
- tick_in asserted during reset is ignored.
- No combinational path from raw_in to any output.

Test Plan:
- DEB_COUNT=4, SYNC_STAGES=2, tick_in=1. raw_in[0] steps 0->1 and is captured at edge 10 -> level_out[0]=1 after edge 15; rise_out[0]=1 for that cycle only; stable_out low during edges 11-14.
- Same config, raw_in[5] high for 3 cycles then low -> level_out[5], rise_out and fall_out stay 0; stable_out returns to 1 after the glitch.
- tick_in pulsed every 10 clks, raw_in[2] held 1 -> level_out[2] changes on the 4th tick after sync goes high. Counter holds between ticks, verified by dropping raw_in for 5 non-tick cycles without rejection.
- raw_in goes 0x00->0xF3 on one edge, tick_in=1 -> level_out=0xF3 and rise_out=0xF3 on the same cycle, fall_out=0. Then 0xF3->0x30 -> fall_out=0xC3 for one cycle.
- raw_in[7] high and level_out[7]=1, then reset is asserted mid-cycle for 3 clks -> all outputs 0 immediately, no fall pulse. rise_out[7] fires again 5 edges after reset release.
- DEB_COUNT=1 build, tick_in=1 -> level follows raw with a 2-edge latency; alternating raw every cycle produces alternating rise/fall pulses with no overlap.
